// File: rtl/pe_dot.sv
// pe_dot -- streaming signed dot-product processing element.
//
// A small local RAM holds one operand vector. A start request computes
// sum(ain[i] * RAM[i]) for i = 0..len-1 over a valid/ready stream on ain.
// The result is presented on dout/dvalid and held until dready.
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   we, waddr, din     local RAM write port (only honoured while idle)
//   start, len         begin a dot product of min(len, DEPTH) elements
//   ain, ain_valid     streamed operand A
//   ain_ready          element accepted this cycle (RUN only)
//   dout, dvalid       result, held until dready
//   dready             consumer accepts the result
//   busy               any state other than IDLE
//   ovf                signed accumulator overflow occurred in this result
//
// Build option: define PE_DOT_SAT_EN to make the accumulator saturate
// (and stay clamped) instead of wrapping. ovf behaves the same either way.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; RAM writes allowed
// FETCH  | one cycle to read RAM[0] ahead of the first element
// RUN    | ain_ready=1; one element per handshake
// FLUSH  | two cycles to drain the multiply and accumulate stages
// DONE   | dvalid=1, result held until dready

module pe_dot #(
    parameter int DATA_W     = 16,
    parameter int L_RAM_SIZE = 3,
    parameter int ACC_W      = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     we,
    input  logic [L_RAM_SIZE-1:0]    waddr,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     start,
    input  logic [L_RAM_SIZE:0]      len,
    input  logic signed [DATA_W-1:0] ain,
    input  logic                     ain_valid,
    output logic                     ain_ready,
    output logic signed [ACC_W-1:0]  dout,
    output logic                     dvalid,
    input  logic                     dready,
    output logic                     busy,
    output logic                     ovf
);

    localparam int DEPTH = 2**L_RAM_SIZE;
    localparam logic [L_RAM_SIZE:0] DEPTH_LEN = (L_RAM_SIZE+1)'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

`ifdef PE_DOT_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    logic [2:0]                  state_q, state_d;
    logic [L_RAM_SIZE-1:0]       idx_q, idx_d;
    logic [L_RAM_SIZE:0]         rem_q, rem_d;
    logic                        flush_cnt_q, flush_cnt_d;
    logic signed [2*DATA_W-1:0]  prod_q, prod_d;
    logic                        prod_vld_q, prod_vld_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic                        ovf_q, ovf_d;

    logic [L_RAM_SIZE-1:0]       rd_addr;
    logic [L_RAM_SIZE:0]         len_clamp;
    logic signed [ACC_W-1:0]     prod_ext;
    logic signed [ACC_W-1:0]     sum;
    logic                        add_ovf;
    logic                        wr_en;

    logic signed [DATA_W-1:0]    ram_mem [DEPTH];
    logic signed [DATA_W-1:0]    rd_data_q;

    assign len_clamp = (len > DEPTH_LEN) ? DEPTH_LEN : len;
    assign wr_en     = we && (state_q == S_IDLE);

    // Stage 2: overflow when both addends share a sign the sum does not.
    assign prod_ext = ACC_W'(prod_q);
    assign sum      = acc_q + prod_ext;
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        flush_cnt_d = flush_cnt_q;
        prod_d      = prod_q;
        prod_vld_d  = 1'b0;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        // Read address runs one element ahead so RAM[idx] is ready each RUN cycle.
        rd_addr     = idx_q;

        if (prod_vld_q) begin
            if (add_ovf) begin
                ovf_d = 1'b1;
            end
`ifdef PE_DOT_SAT_EN
            // Once saturated the accumulator stays clamped for this result.
            if (ovf_q) begin
                acc_d = acc_q;
            end else if (add_ovf) begin
                acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_d = sum;
            end
`else
            acc_d = sum;
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                    rem_d   = len_clamp;
                    state_d = (len_clamp == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (ain_valid) begin
                    prod_d     = (2*DATA_W)'(ain) * (2*DATA_W)'(rd_data_q);
                    prod_vld_d = 1'b1;
                    idx_d      = idx_q + L_RAM_SIZE'(1);
                    rd_addr    = idx_q + L_RAM_SIZE'(1);
                    rem_d      = rem_q - (L_RAM_SIZE+1)'(1);
                    if (rem_q == (L_RAM_SIZE+1)'(1)) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == 1'b0) begin
                    state_d = S_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (dready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rem_q       <= '0;
            flush_cnt_q <= 1'b0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            flush_cnt_q <= flush_cnt_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            ram_mem[waddr] <= din;
        end
        rd_data_q <= ram_mem[rd_addr];
    end

    assign ain_ready = (state_q == S_RUN);
    assign dvalid    = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign dout      = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pe_dot.sv
// Testbench for pe_dot: table of directed vectors, hand-written sequences
// for busy-time writes/starts and mid-operation reset, then randomized
// runs checked against an arithmetic reference model.

module tb_pe_dot;

`ifdef PE_DOT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam longint AMAX = 64'sd2147483647;
    localparam longint AMIN = -64'sd2147483648;

    logic               aclk;
    logic               aresetn;
    logic               we;
    logic [2:0]         waddr;
    logic [15:0]        din;
    logic               start;
    logic [3:0]         len;
    logic [15:0]        ain;
    logic               ain_valid;
    logic               ain_ready;
    logic signed [31:0] dout;
    logic               dvalid;
    logic               dready;
    logic               busy;
    logic               ovf;

    int total = 0;
    int bad   = 0;

    logic [15:0] ram_m [8];

    typedef struct {
        int              n_len;
        logic [7:0][15:0] ram;
        logic [7:0][15:0] a;
        int              gap;
        int              hold;
        longint          exp_d;
        bit              exp_o;
        int              exp_hs;
    } vec_t;

    vec_t vecs [7];

    pe_dot dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .we        (we),
        .waddr     (waddr),
        .din       (din),
        .start     (start),
        .len       (len),
        .ain       (ain),
        .ain_valid (ain_valid),
        .ain_ready (ain_ready),
        .dout      (dout),
        .dvalid    (dvalid),
        .dready    (dready),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog timeout");
    end

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic ram_wr(input int a, input logic [15:0] d);
        we    = 1'b1;
        waddr = 3'(a);
        din   = d;
        step();
        we    = 1'b0;
        ram_m[a] = d;
    endtask

    task automatic load(input logic [7:0][15:0] rv);
        for (int i = 0; i < 8; i++) ram_wr(i, rv[i]);
    endtask

    // Reference: plain 64-bit arithmetic, then wrap or clamp to 32 bits.
    function automatic longint model(input int n_len, input logic [7:0][15:0] av, output bit o);
        longint acc, s, p;
        bit     ovl;
        int     n;
        n   = (n_len > 8) ? 8 : n_len;
        acc = 0;
        o   = 1'b0;
        for (int i = 0; i < n; i++) begin
            p   = longint'($signed(ram_m[i])) * longint'($signed(av[i]));
            s   = acc + p;
            ovl = (s > AMAX) || (s < AMIN);
            if (SAT && o) acc = acc;
            else if (ovl) acc = SAT ? ((s > 0) ? AMAX : AMIN) : longint'(int'(s));
            else acc = s;
            if (ovl) o = 1'b1;
        end
        return acc;
    endfunction

    task automatic run_check(input string nm, input int n_len, input logic [7:0][15:0] av,
                             input int gap, input int hold, input longint exp_d,
                             input bit exp_o, input int exp_hs);
        int cyc, last_hs, n_hs;
        bit hs_now, tog;
        n_hs = 0; last_hs = 0; cyc = 0; tog = 1'b1;
        // ain_valid is raised with start: an idle PE must not take it.
        start = 1'b1; len = 4'(n_len); ain_valid = 1'b1; ain = 16'h7fff; dready = 1'b0;
        step();
        cyc = 1; start = 1'b0; ain_valid = 1'b0;
        while (!dvalid && cyc < 200) begin
            case (gap)
                0: ain_valid = 1'b1;
                1: begin ain_valid = tog; tog = !tog; end
                default: ain_valid = 1'($urandom_range(0, 1));
            endcase
            ain    = av[n_hs % 8];
            hs_now = ain_ready && ain_valid;
            step();
            if (hs_now) begin
                n_hs++;
                last_hs = cyc;
            end
            cyc++;
        end
        ain_valid = 1'b0;
        chk({nm, " dvalid"}, dvalid, 1);
        chk({nm, " dout"}, dout, exp_d);
        chk({nm, " ovf"}, ovf, exp_o);
        chk({nm, " handshakes"}, n_hs, exp_hs);
        chk({nm, " latency"}, (n_len == 0) ? cyc : cyc - last_hs, (n_len == 0) ? 1 : 3);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({nm, " dout_hold"}, dout, exp_d);
            chk({nm, " dvalid_hold"}, dvalid, 1);
        end
        dready = 1'b1;
        step();
        dready = 1'b0;
        chk({nm, " idle_after_dready"}, busy, 0);
    endtask

    logic [7:0][15:0] rv, av;
    int  n, t;
    bit  o;
    longint e;

    initial begin
        aresetn = 1'b0; start = 1'b0; we = 1'b0; waddr = '0; din = '0;
        len = '0; ain = '0; ain_valid = 1'b0; dready = 1'b0;

        vecs[0] = '{4, {16'd0,16'd0,16'd0,16'd0,16'd4,16'd3,16'd2,16'd1},
                       {16'd0,16'd0,16'd0,16'd0,16'd8,16'd7,16'd6,16'd5}, 0, 0, 70, 1'b0, 4};
        vecs[1] = '{4, {16'd0,16'd0,16'd0,16'd0,16'd4,16'd3,16'd2,16'd1},
                       {16'd0,16'd0,16'd0,16'd0,16'd8,16'd7,16'd6,16'd5}, 1, 5, 70, 1'b0, 4};
        vecs[2] = '{8, {8{16'h8000}}, {8{16'h8000}}, 0, 0, SAT ? AMAX : 0, 1'b1, 8};
        vecs[3] = '{0, {16'd0,16'd0,16'd0,16'd0,16'd4,16'd3,16'd2,16'd1},
                       {8{16'd5}}, 0, 2, 0, 1'b0, 0};
        vecs[4] = '{15, {16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1},
                        {8{16'd1}}, 0, 0, 36, 1'b0, 8};
        vecs[5] = '{3, {16'd0,16'd0,16'd0,16'd0,16'd100,16'd0,16'd7,16'hFFFD},
                       {16'd0,16'd0,16'd0,16'd0,16'hFFFF,16'd9,16'hFFFB,16'd2}, 0, 1, -41, 1'b0, 3};
        vecs[6] = '{8, {16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1},
                       {16'd1,16'd2,16'd3,16'd4,16'd5,16'd6,16'd7,16'd8}, 2, 0, 120, 1'b0, 8};

        repeat (3) @(posedge aclk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset dvalid", dvalid, 0);
        chk("reset ain_ready", ain_ready, 0);
        chk("reset ovf", ovf, 0);
        chk("reset dout", dout, 0);
        aresetn = 1'b1;

        for (int r = 0; r < 7; r++) begin
            load(vecs[r].ram);
            run_check($sformatf("vec%0d", r), vecs[r].n_len, vecs[r].a, vecs[r].gap,
                      vecs[r].hold, vecs[r].exp_d, vecs[r].exp_o, vecs[r].exp_hs);
        end

        // Writes and a second start while busy are both ignored.
        load({16'd0,16'd0,16'd0,16'd0,16'd4,16'd3,16'd2,16'd1});
        start = 1'b1; len = 4'd4; step(); start = 1'b0;
        we = 1'b1; waddr = 3'd2; din = 16'd99; step();
        ain_valid = 1'b1; ain = 16'd5; step();
        ain = 16'd6; start = 1'b1; len = 4'd1; step();
        we = 1'b0; start = 1'b0; ain = 16'd7; step();
        ain = 16'd8; step();
        ain_valid = 1'b0;
        t = 0;
        while (!dvalid && t < 20) begin
            step();
            t++;
        end
        chk("busy_ign dvalid", dvalid, 1);
        chk("busy_ign dout", dout, 70);
        dready = 1'b1; step(); dready = 1'b0; step();
        chk("busy_ign no_restart", busy, 0);
        run_check("busy_ign ram2_kept", 3, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd1,16'd0,16'd0},
                  0, 0, 3, 1'b0, 3);

        // Reset in the middle of RUN, then a fresh single-element product.
        ram_wr(0, 16'd3);
        start = 1'b1; len = 4'd4; step(); start = 1'b0; step();
        ain_valid = 1'b1; ain = 16'd9; step(); step(); ain_valid = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst dvalid", dvalid, 0);
        chk("midrst ain_ready", ain_ready, 0);
        chk("midrst dout", dout, 0);
        chk("midrst ovf", ovf, 0);
        step();
        aresetn = 1'b1;
        run_check("after_reset", 1, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd4},
                  0, 0, 12, 1'b0, 1);

        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 8; k++) begin
                rv[k] = 16'($urandom);
                av[k] = 16'($urandom);
            end
            load(rv);
            n = $urandom_range(0, 15);
            e = model(n, av, o);
            run_check($sformatf("rand%0d", it), n, av, $urandom_range(0, 2),
                      $urandom_range(0, 3), e, o, (n > 8) ? 8 : n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_dot.md
PE_DOT -- requirements
Module: pe_dot

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed operand width of ain, din and the local RAM words.
REQ-002 SHALL have parameter L_RAM_SIZE, default 3: log2 of local RAM depth, giving DEPTH = 2**L_RAM_SIZE.
REQ-003 SHALL have parameter ACC_W, default 32: signed accumulator and dout width, with ACC_W >= 2*DATA_W.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports ordered aclk first, then aresetn:
  - aclk  input  1  sole clock; all state on rising edge
  - aresetn  input  1  asynchronous active-low reset
  - we  input  1  local RAM write strobe
  - waddr  input  L_RAM_SIZE  RAM write address
  - din  input  DATA_W  RAM write data
  - start  input  1  single-cycle request to begin a dot product
  - len  input  L_RAM_SIZE+1  element count, sampled on accepted start
  - ain  input  DATA_W  streamed operand A
  - ain_valid  input  1  ain qualifier
  - ain_ready  output  1  PE accepts ain this cycle
  - dout  output  ACC_W  dot-product result
  - dvalid  output  1  dout valid; held until dready
  - dready  input  1  consumer accepts dout
  - busy  output  1  high in any state other than IDLE
  - ovf  output  1  signed overflow occurred in this result

Function
REQ-005 SHALL implement an FSM with states IDLE, FETCH, RUN, FLUSH and DONE.
REQ-006 IDLE SHALL move on start=1 to FETCH, or to DONE if the clamped len is 0; the clamped len is min(len, DEPTH).
REQ-007 FETCH SHALL last exactly 1 cycle, reading RAM[0], then move to RUN.
REQ-008 RUN SHALL drive ain_ready=1; each ain_valid&&ain_ready handshake consumes element idx (0..len-1) against RAM[idx].
REQ-009 RUN SHALL sustain 1 element/cycle with gaps allowed; ain_valid=0 stalls idx and the pipeline inputs.
REQ-010 The handshake on the last element SHALL move RUN to FLUSH, and ain_ready SHALL be 0 in every state except RUN.
REQ-011 The datapath SHALL be 2 stages: stage 1 registers the full signed 2*DATA_W product ain*RAM[idx]; stage 2 sign-extends it and adds it into the ACC_W accumulator.
REQ-012 FLUSH SHALL last exactly 2 cycles, so dvalid rises exactly 3 cycles after the last ain handshake; the FSM then enters DONE.
REQ-013 DONE SHALL drive dvalid=1 and hold dout and ovf stable until dvalid&&dready, then return to IDLE on the next edge.
REQ-014 A len=0 request SHALL give DONE one cycle after start, with dout=0 and ovf=0.
REQ-015 The accumulator and ovf SHALL clear on every accepted start.
REQ-016 ovf SHALL be set when any stage-2 addition overflows signed ACC_W, and SHALL remain set for that result.
REQ-017 A write with we=1 in IDLE SHALL update RAM[waddr] on that edge; we=1 while busy=1 SHALL be ignored (RAM unchanged).
REQ-018 start=1 while busy=1 SHALL be ignored.
REQ-019 The RAM SHALL be synchronous-read with 1-cycle latency and SHALL be inferred as block RAM; RAM contents SHALL NOT be reset.
REQ-020 start and ain_valid arriving in the same cycle in IDLE SHALL NOT consume ain.

Reset
REQ-021 aresetn=0 SHALL asynchronously force state=IDLE, dvalid=0, ain_ready=0, busy=0, ovf=0, dout=0, accumulator=0 and idx=0.
REQ-022 A reset mid-operation SHALL abandon the operation with no result emitted; RAM contents persist.
REQ-023 Reset deassertion SHALL be synchronous to aclk; the first start is accepted on the 1st edge after release.

Configuration
REQ-024 Macro PE_DOT_SAT_EN SHALL select the overflow handling; ovf behaviour is identical in both builds.
  - Defined: each stage-2 sum saturates to +(2**(ACC_W-1))-1 or -(2**(ACC_W-1)), and the accumulator remains clamped on further additions.
  - Undefined: sums wrap modulo 2**ACC_W.

Verification
REQ-025 Load RAM[0..3]={1,2,3,4}, start len=4, stream ain={5,6,7,8} back-to-back -> dout=70, ovf=0, dvalid exactly 3 cycles after last handshake.
REQ-026 Same load; ain_valid toggling 1,0,1,0,... plus dready held 0 for 5 cycles -> dout=70, held stable, IDLE one cycle after dready=1.
REQ-027 DATA_W=16, ACC_W=32, RAM all -32768, ain all -32768, len=8 -> ovf=1; with PE_DOT_SAT_EN dout=2147483647, without dout=0.
REQ-028 start len=0 -> dvalid=1 next cycle, dout=0; start len=15 with L_RAM_SIZE=3 -> exactly 8 handshakes consumed.
REQ-029 we=1 waddr=2 din=99 while busy, then start/ain pulse mid-RUN -> RAM[2] unchanged, second start ignored.
REQ-030 aresetn=0 during RUN after 2 elements, then new start len=1 with RAM[0]=3, ain=4 -> dout=12, no stale accumulation.
